// File: rtl/alu_share_scheduler.sv
// -----------------------------------------------------------------------------
// alu_share_scheduler
//
// Time-shares one 8-bit compact ALU (OR/NAND/NOR/AND/ADD/SUB) between two
// independent requesters. A round-robin arbiter picks a winner in IDLE. The
// winning opcode and operands are registered onto the ALU inputs. The
// combinational ALU result is captured one cycle later. It is then returned
// with the requester ID over a valid/ready response channel. At most one
// operation is in flight.
//
// Parameters
//   UUID  instance identifier, XORed into child UUIDs
//   NAME  instance name string
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   Req{0,1}_Valid           request pending from client 0 / 1
//   Req{0,1}_Code/_A/_B      opcode and operands
//   Req{0,1}_Ready           request accepted this cycle when high with Valid
//   Alu_Code                 registered opcode to the ALU
//   Alu_Input_1/_2           registered operands to the ALU
//   Alu_Result               combinational ALU result
//   Rsp_Valid/Rsp_Ready      response handshake
//   Rsp_Id                   originating client of the response
//   Rsp_Data                 captured ALU result
//   Rsp_Error                illegal-opcode flag
//   Op_Count                 completed response handshakes, wraps at 16 bits
//
// Build option
//   ALU_SCHED_OPCHECK_EN     when defined, a response to an opcode >= 6 has
//                            Rsp_Data=0x00 and Rsp_Error=1. When undefined,
//                            Rsp_Error is tied low and such codes pass through
//                            unchecked.
// -----------------------------------------------------------------------------
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no operation in flight; grant a requester, latch its payload
// EXEC   | ALU inputs stable; capture Alu_Result at the end of the cycle
// RESP   | response presented; wait for Rsp_Ready, then count and go idle

module alu_share_scheduler #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        Req0_Valid,
  input  logic [7:0]  Req0_Code,
  input  logic [7:0]  Req0_A,
  input  logic [7:0]  Req0_B,
  output logic        Req0_Ready,

  input  logic        Req1_Valid,
  input  logic [7:0]  Req1_Code,
  input  logic [7:0]  Req1_A,
  input  logic [7:0]  Req1_B,
  output logic        Req1_Ready,

  output logic [7:0]  Alu_Code,
  output logic [7:0]  Alu_Input_1,
  output logic [7:0]  Alu_Input_2,
  input  logic [7:0]  Alu_Result,

  output logic        Rsp_Valid,
  output logic        Rsp_Id,
  output logic [7:0]  Rsp_Data,
  output logic        Rsp_Error,
  input  logic        Rsp_Ready,

  output logic [15:0] Op_Count
);

  // The scheduler has no child instances, so the identity parameters have
  // nothing to feed. This empty block only keeps them referenced.
  if (UUID == -1 && NAME == "__alu_share_scheduler_unused__") begin : g_ident
  end

  localparam logic [7:0] LAST_LEGAL_CODE = 8'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic   ptr;        // preferred client when both request
  logic   grant_id;   // client that wins arbitration this cycle
  logic   accept;     // a request handshake completes at this edge
  logic   capture;    // Alu_Result is sampled at this edge
  logic   rsp_fire;   // response handshake completes at this edge

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, arbitration and handshake strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    grant_id   = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_fire   = 1'b0;
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    Rsp_Valid  = 1'b0;

    // A lone requester always wins. With both requesting, the pointer decides.
    if (Req0_Valid && Req1_Valid) begin
      grant_id = ptr;
    end else begin
      grant_id = Req1_Valid;
    end

    unique case (state)
      S_IDLE: begin
        // Gating with rst keeps Ready low for the whole reset pulse. The
        // state register alone would already force IDLE, which would leave
        // Ready free to follow Valid.
        Req0_Ready = rst && Req0_Valid && !grant_id;
        Req1_Ready = rst && Req1_Valid &&  grant_id;
        accept     = Req0_Ready || Req1_Ready;
        if (accept) begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        capture    = 1'b1;
        next_state = S_RESP;
      end
      S_RESP: begin
        Rsp_Valid = 1'b1;
        if (Rsp_Ready) begin
          rsp_fire   = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue side: ALU operand registers, requester ID and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Alu_Code    <= 8'h00;
      Alu_Input_1 <= 8'h00;
      Alu_Input_2 <= 8'h00;
      Rsp_Id      <= 1'b0;
      ptr         <= 1'b0;
    end else if (accept) begin
      if (grant_id) begin
        Alu_Code    <= Req1_Code;
        Alu_Input_1 <= Req1_A;
        Alu_Input_2 <= Req1_B;
      end else begin
        Alu_Code    <= Req0_Code;
        Alu_Input_1 <= Req0_A;
        Alu_Input_2 <= Req0_B;
      end
      Rsp_Id <= grant_id;
      // The client just served loses priority, even if it was the only one
      // requesting.
      ptr    <= ~grant_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Response side: result capture and error flag
  // ---------------------------------------------------------------------------
`ifdef ALU_SCHED_OPCHECK_EN
  logic rsp_error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Rsp_Data    <= 8'h00;
      rsp_error_q <= 1'b0;
    end else if (capture) begin
      // An illegal code still runs through EXEC. Its result is then replaced
      // by zero so a misbehaving ALU cannot leak data for it.
      if (Alu_Code > LAST_LEGAL_CODE) begin
        Rsp_Data    <= 8'h00;
        rsp_error_q <= 1'b1;
      end else begin
        Rsp_Data    <= Alu_Result;
        rsp_error_q <= 1'b0;
      end
    end
  end

  assign Rsp_Error = rsp_error_q;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Rsp_Data <= 8'h00;
    end else if (capture) begin
      Rsp_Data <= Alu_Result;
    end
  end

  assign Rsp_Error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Completed-operation counter, free-running wrap at 16 bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Op_Count <= 16'h0000;
    end else if (rsp_fire) begin
      Op_Count <= Op_Count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Bench for alu_share_scheduler. The bench also acts as the shared ALU.
module tb_alu_share_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Req0_Valid = 1'b0, Req1_Valid = 1'b0;
  logic [7:0]  Req0_Code = 8'h00, Req0_A = 8'h00, Req0_B = 8'h00;
  logic [7:0]  Req1_Code = 8'h00, Req1_A = 8'h00, Req1_B = 8'h00;
  logic        Req0_Ready, Req1_Ready;
  logic [7:0]  Alu_Code, Alu_Input_1, Alu_Input_2, Alu_Result;
  logic        Rsp_Valid, Rsp_Id, Rsp_Error;
  logic [7:0]  Rsp_Data;
  logic        Rsp_Ready = 1'b1;
  logic [15:0] Op_Count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_scheduler dut (
    .clk(clk), .rst(rst),
    .Req0_Valid(Req0_Valid), .Req0_Code(Req0_Code), .Req0_A(Req0_A), .Req0_B(Req0_B), .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid), .Req1_Code(Req1_Code), .Req1_A(Req1_A), .Req1_B(Req1_B), .Req1_Ready(Req1_Ready),
    .Alu_Code(Alu_Code), .Alu_Input_1(Alu_Input_1), .Alu_Input_2(Alu_Input_2), .Alu_Result(Alu_Result),
    .Rsp_Valid(Rsp_Valid), .Rsp_Id(Rsp_Id), .Rsp_Data(Rsp_Data), .Rsp_Error(Rsp_Error), .Rsp_Ready(Rsp_Ready),
    .Op_Count(Op_Count)
  );

  function automatic logic [7:0] alu_fn(input logic [7:0] code, input logic [7:0] a, input logic [7:0] b);
    case (code)
      8'd0:    return a | b;
      8'd1:    return ~(a & b);
      8'd2:    return ~(a | b);
      8'd3:    return a & b;
      8'd4:    return a + b;
      8'd5:    return a - b;
      default: return 8'h00;
    endcase
  endfunction

  assign Alu_Result = alu_fn(Alu_Code, Alu_Input_1, Alu_Input_2);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one op at a time. The response is due two edges after
  // acceptance and is held until it is taken.
  // ---------------------------------------------------------------------------
  bit          m_busy = 0;
  int          m_age  = 0;
  bit          m_ptr  = 0;
  bit          m_id   = 0;
  logic [7:0]  m_code = 0, m_a = 0, m_b = 0, m_data = 0;
  bit          m_err  = 0;
  logic [15:0] m_count = 0;
  bit          e_r0, e_r1, e_rv;

  logic        log_id[$];
  logic [7:0]  log_data[$];
  logic        log_err[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ready0", {15'd0, Req0_Ready}, 16'd0);
      chk("rst_ready1", {15'd0, Req1_Ready}, 16'd0);
      chk("rst_rsp_valid", {15'd0, Rsp_Valid}, 16'd0);
      chk("rst_alu", {Alu_Code, Alu_Input_1 | Alu_Input_2}, 16'd0);
      chk("rst_rsp", {6'd0, Rsp_Id, Rsp_Error, Rsp_Data}, 16'd0);
      chk("rst_op_count", Op_Count, 16'd0);
      m_busy = 0; m_age = 0; m_ptr = 0; m_id = 0;
      m_code = 0; m_a = 0; m_b = 0; m_count = 0;
    end else begin
      e_r0 = !m_busy && Req0_Valid && (!Req1_Valid || m_ptr == 1'b0);
      e_r1 = !m_busy && Req1_Valid && (!Req0_Valid || m_ptr == 1'b1);
      e_rv = m_busy && (m_age >= 2);
      chk("ready0", {15'd0, Req0_Ready}, {15'd0, e_r0});
      chk("ready1", {15'd0, Req1_Ready}, {15'd0, e_r1});
      chk("alu_code", {8'd0, Alu_Code}, {8'd0, m_code});
      chk("alu_in", {Alu_Input_1, Alu_Input_2}, {m_a, m_b});
      chk("rsp_valid", {15'd0, Rsp_Valid}, {15'd0, e_rv});
      if (e_rv) begin
        chk("rsp_id", {15'd0, Rsp_Id}, {15'd0, m_id});
        chk("rsp_data", {8'd0, Rsp_Data}, {8'd0, m_data});
        chk("rsp_error", {15'd0, Rsp_Error}, {15'd0, m_err});
      end
      chk("op_count", Op_Count, m_count);
      if (e_rv && Rsp_Ready) begin
        log_id.push_back(Rsp_Id);
        log_data.push_back(Rsp_Data);
        log_err.push_back(Rsp_Error);
        m_busy  = 0;
        m_count = m_count + 16'd1;
      end else if (m_busy) begin
        m_age++;
      end else if (e_r0 || e_r1) begin
        m_id   = e_r1;
        m_code = e_r1 ? Req1_Code : Req0_Code;
        m_a    = e_r1 ? Req1_A : Req0_A;
        m_b    = e_r1 ? Req1_B : Req0_B;
        m_data = alu_fn(m_code, m_a, m_b);
`ifdef ALU_SCHED_OPCHECK_EN
        m_err  = (m_code > 8'd5);
`else
        m_err  = 1'b0;
`endif
        m_ptr  = !m_id;
        m_busy = 1;
        m_age  = 1;
      end
    end
  end

  // Presents one request, holds it until Ready is seen, and returns one cycle
  // into EXEC (+1 time unit).
  task automatic issue(input bit c, input logic [7:0] code, input logic [7:0] a, input logic [7:0] b);
    bit got;
    got = 0;
    @(posedge clk); #1;
    if (c) begin Req1_Valid = 1; Req1_Code = code; Req1_A = a; Req1_B = b; end
    else   begin Req0_Valid = 1; Req0_Code = code; Req0_A = a; Req0_B = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = c ? Req1_Ready : Req0_Ready;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: client %0d not granted, required grant within 20 cycles", c);
    end
    @(posedge clk); #1;
    if (c) Req1_Valid = 0; else Req0_Valid = 0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 40 && log_id.size() < n; i++) @(posedge clk);
    if (log_id.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL wait_rsp: got %0d responses, required %0d", log_id.size(), n);
    end
    #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic id, input logic [7:0] data, input logic err);
    if (idx < log_id.size()) begin
      chk(name, {6'd0, log_err[idx], log_id[idx], log_data[idx]}, {6'd0, err, id, data});
    end else begin
      n_tests++; n_fail++;
      $display("FAIL %s: no response %0d logged, required id %0d data %h", name, idx, id, data);
    end
  endtask

  initial begin
    int base;
    logic [15:0] snap;
    logic exp_err9;
`ifdef ALU_SCHED_OPCHECK_EN
    exp_err9 = 1'b1;
`else
    exp_err9 = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Client 0 ADD 0x7F + 0x01.
    base = log_id.size();
    issue(0, 8'd4, 8'h7F, 8'h01);
    chk("t1_alu_code_n1", {8'd0, Alu_Code}, 16'h0004);
    chk("t1_no_rsp_n1", {15'd0, Rsp_Valid}, 16'd0);
    @(posedge clk); #1;
    chk("t1_rsp_valid_n2", {15'd0, Rsp_Valid}, 16'd1);
    wait_log(base + 1);
    chk_log("t1_add", base, 1'b0, 8'h80, 1'b0);
    chk("t1_op_count", Op_Count, 16'd1);

    // Client 1 SUB 0x05 - 0x07.
    base = log_id.size();
    issue(1, 8'd5, 8'h05, 8'h07);
    wait_log(base + 1);
    chk_log("t2_sub", base, 1'b1, 8'hFE, 1'b0);

    // Both clients continuously valid: strict alternation starting at 0.
    base = log_id.size();
    @(posedge clk); #1;
    Req0_Valid = 1; Req0_Code = 8'd0; Req0_A = 8'hF0; Req0_B = 8'h0F;
    Req1_Valid = 1; Req1_Code = 8'd3; Req1_A = 8'hF0; Req1_B = 8'h3C;
    wait_log(base + 4);
    Req0_Valid = 0; Req1_Valid = 0;
    repeat (6) @(posedge clk);
    chk_log("t3_rr0", base,     1'b0, 8'hFF, 1'b0);
    chk_log("t3_rr1", base + 1, 1'b1, 8'h30, 1'b0);
    chk_log("t3_rr2", base + 2, 1'b0, 8'hFF, 1'b0);
    chk_log("t3_rr3", base + 3, 1'b1, 8'h30, 1'b0);

    // Response back-pressure with a competing request waiting.
    base = log_id.size();
    Rsp_Ready = 0;
    issue(0, 8'd2, 8'h0F, 8'h30);
    Req1_Valid = 1; Req1_Code = 8'd1; Req1_A = 8'hFF; Req1_B = 8'h0F;
    @(posedge clk); #1;
    snap = Op_Count;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {15'd0, Rsp_Valid}, 16'd1);
      chk("t4_hold_data", {7'd0, Rsp_Id, Rsp_Data}, {8'd0, 8'hC0});
      chk("t4_hold_ready", {14'd0, Req0_Ready, Req1_Ready}, 16'd0);
      chk("t4_hold_count", Op_Count, snap);
      @(posedge clk); #1;
    end
    Rsp_Ready = 1;
    issue(1, 8'd1, 8'hFF, 8'h0F);
    wait_log(base + 2);
    chk_log("t4_nor", base,     1'b0, 8'hC0, 1'b0);
    chk_log("t4_nand", base + 1, 1'b1, 8'hF0, 1'b0);

    // Reset in EXEC after serving client 0 (pointer would move to client 1).
    issue(0, 8'd4, 8'h01, 8'h02);
    rst = 0;
    #1;
    chk("t5_rst_rsp_valid", {15'd0, Rsp_Valid}, 16'd0);
    chk("t5_rst_alu", {Alu_Code, Alu_Input_1 | Alu_Input_2}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    base = log_id.size();
    repeat (3) @(posedge clk);
    chk("t5_no_stale", log_id.size(), base);
    #1;
    Req0_Valid = 1; Req0_Code = 8'd3; Req0_A = 8'hAA; Req0_B = 8'h0F;
    Req1_Valid = 1; Req1_Code = 8'd0; Req1_A = 8'h01; Req1_B = 8'h02;
    wait_log(base + 1);
    Req0_Valid = 0; Req1_Valid = 0;
    chk_log("t5_first_grant", base, 1'b0, 8'h0A, 1'b0);
    chk("t5_op_count", Op_Count, 16'd1);
    repeat (4) @(posedge clk);

    // Illegal opcode.
    base = log_id.size();
    issue(0, 8'h09, 8'h12, 8'h34);
    wait_log(base + 1);
    chk_log("t6_illegal", base, 1'b0, 8'h00, exp_err9);
    chk("t6_op_count", Op_Count, 16'd2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
